// File: rtl/tlb_ctrl.sv
// TLB entry array controller: indexed/random writes, multi-cycle invalidation
// scan and an optional one-cycle registered search port.
// Optional feature: define LAIN_TLB_SRCH_EN to build the search path.

package tlb_ctrl_pkg;
  localparam int unsigned ASID_W = 10;
  localparam int unsigned VPN_W  = 19;
  localparam int unsigned PS_W   = 6;
  localparam int unsigned PPN_W  = 20;

  typedef struct packed {
    logic              e;
    logic              g;
    logic [PS_W-1:0]   ps;
    logic [ASID_W-1:0] asid;
    logic [VPN_W-1:0]  vpn;
  } tlb_key_t;

  typedef struct packed {
    tlb_key_t          key;
    logic [PPN_W-1:0]  ppn;
  } tlb_entry_t;

  typedef struct packed {
    logic              clr_global;
    logic              clr_nonglobal;
    logic              check_asid;
    logic              check_vpn;
    logic [ASID_W-1:0] asid;
    logic [VPN_W-1:0]  vpn;
  } tlb_inv_req_t;
endpackage

module tlb_ctrl
  import tlb_ctrl_pkg::*;
#(
  parameter int unsigned TLB_ENTRY_NUM = 16,
  parameter int unsigned INV_PER_CYCLE = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tlb_we_i,
  input  logic                             tlb_fill_i,
  input  logic [$clog2(TLB_ENTRY_NUM)-1:0] tlb_w_index_i,
  input  tlb_entry_t                       tlb_w_entry_i,
  input  logic                             inv_valid_i,
  output logic                             inv_ready_o,
  input  tlb_inv_req_t                     tlb_inv_req_i,
  output logic                             inv_done_o,
  input  logic                             srch_valid_i,
  input  logic [ASID_W-1:0]                srch_asid_i,
  input  logic [VPN_W-1:0]                 srch_vpn_i,
  output logic                             srch_hit_o,
  output logic [$clog2(TLB_ENTRY_NUM)-1:0] srch_index_o,
  output tlb_entry_t                       entries_o [TLB_ENTRY_NUM]
);

  localparam int unsigned IDX_W     = $clog2(TLB_ENTRY_NUM);
  localparam int unsigned ENTRY_W   = $bits(tlb_entry_t);
  localparam int unsigned BODY_W    = ENTRY_W - 1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'h0001;
  localparam logic [PS_W-1:0] PS_4K = PS_W'(12);
  localparam logic [IDX_W-1:0] LAST_PTR  = IDX_W'(TLB_ENTRY_NUM - INV_PER_CYCLE);
  localparam logic [IDX_W-1:0] PTR_STEP  = IDX_W'(INV_PER_CYCLE);
  localparam logic [IDX_W-1:0] GRP_MASK  = ~IDX_W'(INV_PER_CYCLE - 1);

  typedef enum logic {ST_IDLE, ST_SCAN} state_e;

  // Entry storage: valid bits are reset, the rest of each entry is not.
  logic [TLB_ENTRY_NUM-1:0] e_q;
  logic [BODY_W-1:0]        body_q [TLB_ENTRY_NUM];
  tlb_entry_t               entries_c [TLB_ENTRY_NUM];

  logic [15:0]              lfsr_q;
  logic [IDX_W-1:0]         fill_idx_c;
  logic [TLB_ENTRY_NUM-1:0] wr_sel_c;
  logic [TLB_ENTRY_NUM-1:0] clr_c;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         ptr_q;
  tlb_inv_req_t             req_q;
  logic                     accept_c;
  logic                     scan_c;
  logic                     last_grp_c;
  logic                     inv_ready_d, inv_done_d;
  logic                     inv_ready_q, inv_done_q;

  // VPN compare honouring 4 KiB pages; larger pages ignore the low 10 bits.
  function automatic logic vpn_match(input tlb_key_t k, input logic [VPN_W-1:0] vpn);
    vpn_match = (k.vpn[VPN_W-1:10] == vpn[VPN_W-1:10]) &&
                ((k.ps != PS_4K) || (k.vpn[9:0] == vpn[9:0]));
  endfunction

  // Invalidation match rule for one entry key against the captured descriptor.
  function automatic logic inv_match(input tlb_key_t k, input tlb_inv_req_t r);
    inv_match = (r.clr_global && k.g) ||
                (r.clr_nonglobal && !k.g &&
                 (!r.check_asid || ((k.asid == r.asid) &&
                                    (!r.check_vpn || vpn_match(k, r.vpn)))));
  endfunction

  // Assemble the visible array from the valid bits and the unreset bodies.
  always_comb begin
    for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
      entries_c[i] = tlb_entry_t'({e_q[i], body_q[i]});
    end
  end

  assign entries_o = entries_c;

  // Galois LFSR that free-runs to pick the random fill slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign fill_idx_c = lfsr_q[IDX_W-1:0];

  // Per-entry write select and scan clear; indexed write wins over fill.
  always_comb begin
    wr_sel_c = '0;
    clr_c    = '0;
    for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
      wr_sel_c[i] = (tlb_we_i && (tlb_w_index_i == IDX_W'(i))) ||
                    (tlb_fill_i && !tlb_we_i && (fill_idx_c == IDX_W'(i)));
      clr_c[i]    = scan_c && ((IDX_W'(i) & GRP_MASK) == ptr_q) &&
                    inv_match(entries_c[i].key, req_q);
    end
  end

  // Valid bits: a same-cycle write overrides an invalidation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
    end else begin
      for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
        if (wr_sel_c[i]) begin
          e_q[i] <= tlb_w_entry_i.key.e;
        end else if (clr_c[i]) begin
          e_q[i] <= 1'b0;
        end
      end
    end
  end

  // Entry bodies: data only, no reset needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
      if (wr_sel_c[i]) begin
        body_q[i] <= tlb_w_entry_i[BODY_W-1:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign last_grp_c = (ptr_q == LAST_PTR);

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (inv_valid_i) state_d = ST_SCAN;
      ST_SCAN: if (last_grp_c)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    accept_c    = 1'b0;
    scan_c      = 1'b0;
    inv_done_d  = 1'b0;
    inv_ready_d = 1'b0;
    accept_c    = (state_q == ST_IDLE) && inv_valid_i;
    scan_c      = (state_q == ST_SCAN);
    inv_done_d  = scan_c && last_grp_c;
    inv_ready_d = (state_d == ST_IDLE);
  end

  // Handshake outputs registered; done lands with the final group's clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_ready_q <= 1'b1;
      inv_done_q  <= 1'b0;
    end else begin
      inv_ready_q <= inv_ready_d;
      inv_done_q  <= inv_done_d;
    end
  end

  assign inv_ready_o = inv_ready_q;
  assign inv_done_o  = inv_done_q;

  // Scan pointer and captured descriptor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      req_q <= '0;
    end else if (accept_c) begin
      ptr_q <= '0;
      req_q <= tlb_inv_req_i;
    end else if (scan_c) begin
      ptr_q <= ptr_q + PTR_STEP;
    end
  end

`ifdef LAIN_TLB_SRCH_EN
  logic             srch_hit_c, srch_hit_q;
  logic [IDX_W-1:0] srch_idx_c, srch_idx_q;

  // Search hit rule for one key.
  function automatic logic srch_match(input tlb_key_t k, input logic [ASID_W-1:0] asid,
                                      input logic [VPN_W-1:0] vpn);
    srch_match = k.e && (k.g || (k.asid == asid)) && vpn_match(k, vpn);
  endfunction

  // Lowest-index priority encode over the pre-update array.
  always_comb begin
    srch_hit_c = 1'b0;
    srch_idx_c = '0;
    for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--) begin
      if (srch_match(entries_c[i].key, srch_asid_i, srch_vpn_i)) begin
        srch_hit_c = 1'b1;
        srch_idx_c = IDX_W'(i);
      end
    end
  end

  // Search result register, held until the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srch_hit_q <= 1'b0;
      srch_idx_q <= '0;
    end else if (srch_valid_i) begin
      srch_hit_q <= srch_hit_c;
      srch_idx_q <= srch_idx_c;
    end
  end

  assign srch_hit_o   = srch_hit_q;
  assign srch_index_o = srch_idx_q;
`else
  logic unused_srch;

  assign unused_srch  = ^{srch_valid_i, srch_asid_i, srch_vpn_i};
  assign srch_hit_o   = 1'b0;
  assign srch_index_o = '0;
`endif

endmodule
